// File: rtl/param_stack.sv
// Parametrised LIFO stack with replace-top, sticky overflow/underflow flags,
// an indexed peek port and a high-water mark. Reads are zero-latency.
module param_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             flush,
    input  logic             err_clr,
    input  logic [CW-1:0]    rd_idx,
    output logic [WIDTH-1:0] top_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf,
    output logic [CW-1:0]    hwm
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] count_nxt;
    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic          ovf_set;
    logic          udf_set;
    logic [CW-1:0] top_addr;
    logic [CW-1:0] rd_addr;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top_addr = count - CW'(1);
    assign rd_valid = (rd_idx < count);
    assign rd_addr  = count - CW'(1) - rd_idx;

    always_comb begin
        count_nxt = count;
        wr_en     = 1'b0;
        wr_addr   = count;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            if (!full) begin
                wr_en     = 1'b1;
                wr_addr   = count;
                count_nxt = count + CW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (pop && !push) begin
            if (!empty) begin
                count_nxt = count - CW'(1);
            end else begin
                udf_set = 1'b1;
            end
        end else if (push && pop) begin
            wr_en = 1'b1;
            if (!empty) begin
                wr_addr = top_addr;
            end else begin
                // Push+pop on an empty stack degrades to a plain push but still flags the pop.
                wr_addr   = '0;
                count_nxt = CW'(1);
                udf_set   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == CW'(i))) begin
                mem[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
            hwm   <= '0;
        end else begin
            count <= count_nxt;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
            if (udf_set) begin
                udf <= 1'b1;
            end else if (err_clr) begin
                udf <= 1'b0;
            end
            if (err_clr || (count_nxt > hwm)) begin
                hwm <= count_nxt;
            end
        end
    end

    // Loop-based muxes keep DEPTH free of power-of-two assumptions.
    always_comb begin
        top_data = '0;
        rd_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!empty && (top_addr == CW'(i))) begin
                top_data = mem[i];
            end
            if (rd_valid && (rd_addr == CW'(i))) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at WIDTH=16, DEPTH=4 with hand-computed expectations.
module tb_param_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             flush;
    logic             err_clr;
    logic [CW-1:0]    rd_idx;
    logic [WIDTH-1:0] top_data;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;
    logic [CW-1:0]    hwm;

    int n_checks = 0;
    int n_errors = 0;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
        .flush(flush), .err_clr(err_clr), .rd_idx(rd_idx), .top_data(top_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty),
        .full(full), .ovf(ovf), .udf(udf), .hwm(hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        idle();
        push = 1'b1; push_data = d;
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        flush = 1'b0; err_clr = 1'b0; rd_idx = '0;
        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_top", 32'(top_data), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_udf", 32'(udf), 0);
        chk("rst_hwm", 32'(hwm), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        #4 reset = 1'b1;
        tick();

        // Basic LIFO
        do_push(16'h0011);
        do_push(16'h0022);
        do_push(16'h0033);
        chk("t1_top", 32'(top_data), 32'h33);
        chk("t1_count", 32'(count), 3);
        chk("t1_hwm", 32'(hwm), 3);
        pop = 1'b1;
        chk("t1_pop0", 32'(top_data), 32'h33);
        tick();
        chk("t1_pop1", 32'(top_data), 32'h22);
        tick();
        chk("t1_pop2", 32'(top_data), 32'h11);
        tick();
        idle();
        chk("t1_empty", 32'(empty), 1);
        chk("t1_count_end", 32'(count), 0);

        // Overflow
        do_push(16'd1);
        do_push(16'd2);
        do_push(16'd3);
        do_push(16'd4);
        chk("t2_full", 32'(full), 1);
        chk("t2_ovf_pre", 32'(ovf), 0);
        do_push(16'd5);
        chk("t2_count", 32'(count), 4);
        chk("t2_top", 32'(top_data), 4);
        chk("t2_ovf", 32'(ovf), 1);
        for (int i = 0; i < 3; i++) tick();
        chk("t2_ovf_sticky", 32'(ovf), 1);
        err_clr = 1'b1;
        tick();
        idle();
        chk("t2_ovf_clr", 32'(ovf), 0);
        chk("t2_hwm_clr", 32'(hwm), 4);
        flush = 1'b1;
        tick();
        idle();
        chk("t2_flush_count", 32'(count), 0);
        chk("t2_flush_hwm", 32'(hwm), 4);

        // Underflow and push+pop on empty
        pop = 1'b1;
        tick();
        idle();
        chk("t3_count", 32'(count), 0);
        chk("t3_udf", 32'(udf), 1);
        push = 1'b1; pop = 1'b1; push_data = 16'h00AA;
        tick();
        idle();
        chk("t3_pp_count", 32'(count), 1);
        chk("t3_pp_top", 32'(top_data), 32'hAA);
        chk("t3_pp_udf", 32'(udf), 1);

        // Replace top when full
        flush = 1'b1; err_clr = 1'b1;
        tick();
        idle();
        chk("t4_clr_udf", 32'(udf), 0);
        chk("t4_clr_hwm", 32'(hwm), 0);
        do_push(16'd1);
        do_push(16'd2);
        do_push(16'd3);
        do_push(16'd4);
        push = 1'b1; pop = 1'b1; push_data = 16'hBEEF;
        chk("t4_req_top", 32'(top_data), 4);
        tick();
        idle();
        rd_idx = 3'd1;
        #1;
        chk("t4_count", 32'(count), 4);
        chk("t4_top", 32'(top_data), 32'hBEEF);
        chk("t4_rd1", 32'(rd_data), 3);
        chk("t4_ovf", 32'(ovf), 0);

        // Peek and flush
        flush = 1'b1; err_clr = 1'b1;
        tick();
        idle();
        do_push(16'd1);
        do_push(16'd2);
        do_push(16'd3);
        for (int i = 0; i < 4; i++) begin
            rd_idx = CW'(i);
            #1;
            chk($sformatf("t5_rd_data%0d", i), 32'(rd_data), (i < 3) ? 32'(3 - i) : 0);
            chk($sformatf("t5_rd_valid%0d", i), 32'(rd_valid), (i < 3) ? 1 : 0);
        end
        rd_idx = '0;
        flush = 1'b1; push = 1'b1; push_data = 16'h0077;
        tick();
        idle();
        chk("t5_count", 32'(count), 0);
        chk("t5_ovf", 32'(ovf), 0);
        chk("t5_udf", 32'(udf), 0);
        chk("t5_hwm", 32'(hwm), 3);
        chk("t5_rd_valid", 32'(rd_valid), 0);

        // Error arriving together with err_clr: set wins
        pop = 1'b1; err_clr = 1'b1;
        tick();
        idle();
        chk("t5b_udf_setwins", 32'(udf), 1);
        chk("t5b_hwm_clr", 32'(hwm), 0);

        // Asynchronous reset mid-stream
        do_push(16'h00A1);
        do_push(16'h00A2);
        chk("t6_count_pre", 32'(count), 2);
        #2 reset = 1'b0;
        #1;
        chk("t6_count_async", 32'(count), 0);
        chk("t6_top_async", 32'(top_data), 0);
        chk("t6_udf_async", 32'(udf), 0);
        push = 1'b1; push_data = 16'h0055;
        tick();
        chk("t6_lost_op", 32'(count), 0);
        #4 reset = 1'b1;
        tick();
        idle();
        chk("t6_count_post", 32'(count), 1);
        chk("t6_top_post", 32'(top_data), 32'h55);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
